// File: rtl/cesa_recovery_adder.sv
// Variable-latency carry-estimating segmented adder with misprediction recovery.
// Returns the speculative sum, or the exact sum one cycle later when the estimate was wrong.
module cesa_recovery_adder #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             approx_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             err_o,
  output logic             corrected_o,
  input  logic             clr_cnt_i,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int NB = WIDTH / 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_FIX   = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic             r_approx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_err;
  logic             r_corrected;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_spec_sum;
  logic             w_spec_cout;
  logic [NB-1:0]    w_est;
  logic             w_carry;
  logic [3:0]       w_blk_sum;
  logic [WIDTH:0]   w_exact;
  logic             w_err;
  logic             w_accept;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  function automatic logic blk_est(input logic [3:0] a, input logic [3:0] b);
    logic sel;
    logic pre;
    logic post;
    sel  = (a[3] ^ b[3]) & (a[2] ^ b[2]);
    pre  = maj3(a[1], b[1], a[0] & b[0]);
    post = maj3(a[3], b[3], a[2] & b[2]);
    return sel ? pre : post;
  endfunction

  assign in_ready_o = (r_state == S_IDLE) | ((r_state == S_OUT) & out_ready_i);
  assign w_accept   = in_valid_i & in_ready_o;

  // Speculative sum: each block adds exactly, fed by the previous block's carry estimate.
  always_comb begin
    w_spec_sum = {WIDTH{1'b0}};
    w_est      = {NB{1'b0}};
    w_carry    = r_cin;
    w_blk_sum  = 4'd0;
    for (int k = 0; k < NB; k++) begin
      w_blk_sum             = r_a[4*k +: 4] + r_b[4*k +: 4] + {3'd0, w_carry};
      w_spec_sum[4*k +: 4]  = w_blk_sum;
      w_est[k]              = blk_est(r_a[4*k +: 4], r_b[4*k +: 4]);
      w_carry               = w_est[k];
    end
    w_spec_cout = w_est[NB-1];
  end

  assign w_exact = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
  assign w_err   = ({w_spec_cout, w_spec_sum} != w_exact);

  // Control FSM with registered result outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_a         <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_cin       <= 1'b0;
      r_approx    <= 1'b0;
      r_sum       <= {WIDTH{1'b0}};
      r_cout      <= 1'b0;
      r_err       <= 1'b0;
      r_corrected <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a      <= a_i;
            r_b      <= b_i;
            r_cin    <= cin_i;
            r_approx <= approx_i;
            r_state  <= S_CHECK;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_CHECK: begin
          if (!w_err || r_approx) begin
            r_sum       <= w_spec_sum;
            r_cout      <= w_spec_cout;
            r_err       <= w_err;
            r_corrected <= 1'b0;
            r_valid     <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_state     <= S_FIX;
          end
        end
        S_FIX: begin
          r_sum       <= w_exact[WIDTH-1:0];
          r_cout      <= w_exact[WIDTH];
          r_err       <= 1'b1;
          r_corrected <= 1'b1;
          r_valid     <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready_i) begin
            r_valid <= 1'b0;
            if (in_valid_i) begin
              r_a      <= a_i;
              r_b      <= b_i;
              r_cin    <= cin_i;
              r_approx <= approx_i;
              r_state  <= S_CHECK;
            end else begin
              r_state  <= S_IDLE;
            end
          end else begin
            r_state <= S_OUT;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Saturating misprediction counter; a clear wins over a same-cycle increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (clr_cnt_i) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if ((r_state == S_CHECK) && w_err && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign out_valid_o = r_valid;
  assign sum_o       = r_sum;
  assign cout_o      = r_cout;
  assign err_o       = r_err;
  assign corrected_o = r_corrected;
  assign err_cnt_o   = r_cnt;

endmodule

// File: tb/tb_cesa_recovery_adder.sv
// Directed and random self-checking bench for cesa_recovery_adder (WIDTH=8, CNT_W=2).
module tb_cesa_recovery_adder;

  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic          cin_i = 1'b0;
  logic          approx_i = 1'b0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [W-1:0]  sum_o;
  logic          cout_o;
  logic          err_o;
  logic          corrected_o;
  logic          clr_cnt_i = 1'b0;
  logic [CW-1:0] err_cnt_o;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_model = 0;

  cesa_recovery_adder #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .a_i(a_i), .b_i(b_i), .cin_i(cin_i), .approx_i(approx_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .sum_o(sum_o), .cout_o(cout_o),
    .err_o(err_o), .corrected_o(corrected_o), .clr_cnt_i(clr_cnt_i), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference speculative result {cout, sum}, block by block.
  function automatic logic [W:0] spec_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W-1:0] s;
    logic         c;
    logic [3:0]   x;
    logic [3:0]   y;
    logic         g0;
    logic         g2;
    c = cin;
    s = '0;
    for (int k = 0; k < W/4; k++) begin
      x = a[4*k +: 4];
      y = b[4*k +: 4];
      s[4*k +: 4] = x + y + {3'd0, c};
      g0 = x[0] & y[0];
      g2 = x[2] & y[2];
      if ((x[3] ^ y[3]) && (x[2] ^ y[2]))
        c = (x[1] & y[1]) | (x[1] & g0) | (y[1] & g0);
      else
        c = (x[3] & y[3]) | (x[3] & g2) | (y[3] & g2);
    end
    return {c, s};
  endfunction

  task automatic run_vec(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic apx, input logic clr,
                         input logic [W-1:0] e_sum, input logic e_cout, input logic e_err,
                         input logic e_corr, input int e_lat, input int e_cnt);
    int lat;
    a_i = a; b_i = b; cin_i = cin; approx_i = apx; in_valid_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    clr_cnt_i  = clr;
    lat = 1;
    while (!out_valid_o && lat < 8) begin
      @(posedge clk_i); #1;
      clr_cnt_i = 1'b0;
      lat++;
    end
    clr_cnt_i = 1'b0;
    chk({tag, ".lat"}, lat, e_lat);
    chk({tag, ".sum"}, sum_o, e_sum);
    chk({tag, ".cout"}, cout_o, e_cout);
    chk({tag, ".err"}, err_o, e_err);
    chk({tag, ".corr"}, corrected_o, e_corr);
    chk({tag, ".cnt"}, err_cnt_o, e_cnt);
  endtask

  task automatic idle_cycle();
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  initial begin
    logic [W:0] ex;
    logic [W:0] sp;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc, rx, rclr, re;

    #2;
    chk("rst.valid", out_valid_o, 0);
    chk("rst.ready", in_ready_o, 1);
    chk("rst.sum", sum_o, 0);
    chk("rst.flags", {cout_o, err_o, corrected_o}, 0);
    chk("rst.cnt", err_cnt_o, 0);
    #10 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    run_vec("t1_noerr",  8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 2, 0);
    run_vec("t2_fix",    8'h0F, 8'h00, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 1'b1, 1'b1, 3, 1);
    run_vec("t3_approx", 8'h0F, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2, 2);
    run_vec("t4_coutfx", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3, 3);
    run_vec("t5_noerr",  8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 2, 3);
    run_vec("t6_sat",    8'h0F, 8'h00, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 1'b1, 1'b1, 3, 3);
    run_vec("t7_clr",    8'h0F, 8'h00, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 3, 0);
    run_vec("t8_cout",   8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2, 0);
    run_vec("t9_cin",    8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 2, 0);
    idle_cycle();

    // Back-pressure: result must hold while the consumer stalls.
    a_i = 8'h12; b_i = 8'h34; cin_i = 1'b0; approx_i = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b0;
    @(posedge clk_i); #1;
    in_valid_i = 1'b1;
    chk("stall.check_rdy", in_ready_o, 0);
    in_valid_i = 1'b0;
    @(posedge clk_i); #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall.valid", out_valid_o, 1);
      chk("stall.sum", sum_o, 8'h46);
      chk("stall.ready", in_ready_o, 0);
      @(posedge clk_i); #1;
    end
    a_i = 8'h0F; b_i = 8'h01; in_valid_i = 1'b1; out_ready_i = 1'b1;
    #1 chk("stall.comb_rdy", in_ready_o, 1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    chk("stall.gap", out_valid_o, 0);
    @(posedge clk_i); #1;
    chk("stall.new_valid", out_valid_o, 1);
    chk("stall.new_sum", sum_o, 8'h10);
    idle_cycle();

    cnt_model = 0;
    for (int i = 0; i < 10000; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      rc = 1'($urandom); rx = ($urandom_range(0, 3) == 0);
      rclr = ($urandom_range(0, 49) == 0);
      ex = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      sp = spec_ref(ra, rb, rc);
      re = (sp != ex);
      if (rclr) cnt_model = 0;
      else if (re && cnt_model < 3) cnt_model++;
      if (re && !rx)
        run_vec("rnd", ra, rb, rc, rx, rclr, ex[W-1:0], ex[W], 1'b1, 1'b1, 3, cnt_model);
      else
        run_vec("rnd", ra, rb, rc, rx, rclr, sp[W-1:0], sp[W], re, 1'b0, 2, cnt_model);
    end
    idle_cycle();

    // Reset while in the correction cycle drops the result and clears the counter.
    a_i = 8'h0F; b_i = 8'h00; cin_i = 1'b1; approx_i = 1'b0; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    @(posedge clk_i); #1;
    chk("rstfix.inflight", out_valid_o, 0);
    rst_ni = 1'b0;
    #1;
    chk("rstfix.valid", out_valid_o, 0);
    chk("rstfix.cnt", err_cnt_o, 0);
    chk("rstfix.ready", in_ready_o, 1);
    #2 rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      chk("rstfix.no_out", out_valid_o, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cesa_recovery_adder.md
# cesa_recovery_adder

Sequential, variable-latency wrapper around the carry-estimating segmented adder scheme. It registers an operand pair, computes both the speculative (block-estimated carry) sum and the exact sum, and detects misprediction. It then returns either the speculative result (approximate mode) or the corrected exact result after one extra cycle. It sits between an issuing unit and a consumer, with valid/ready handshakes on both sides.

## Interface
Parameters:
- WIDTH, 32, operand width. Must be a multiple of 4, range 8..64; the number of blocks is NB = WIDTH/4.
- CNT_W, 16, width of the saturating misprediction counter.

Ports:
- clk_i  in  1  clock. Rising-edge.
- rst_ni  in  1  reset. Asynchronous assert, active-low.
- in_valid_i  in  1  operand request valid.
- in_ready_o  out  1  block can accept an operand pair.
- a_i, b_i  in  WIDTH  operands.
- cin_i  in  1  carry-in to block 0.
- approx_i  in  1  1 = return the speculative result with no correction.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- sum_o  out  WIDTH  result sum.
- cout_o  out  1  result carry-out.
- err_o  out  1  the speculative result for this operation differed from the exact result.
- corrected_o  out  1  the result was produced by the correction cycle.
- clr_cnt_i  in  1  synchronous clear of the counter.
- err_cnt_o  out  CNT_W  saturating count of mispredictions.

## Operation
- Carry estimate for block k (bits 4k+3..4k), with a3..a0 and b3..b0 the block's bits:
  - sel = (a3^b3)&(a2^b2).
  - pre = maj(a1, b1, a0&b0).
  - post = maj(a3, b3, a2&b2).
  - est_k = sel ? pre : post.
- Speculative sum:
  - Block 0 carry-in is cin.
  - Block k>0 carry-in is est_(k-1).
  - Each block is an exact 4-bit ripple add with that carry-in.
  - Speculative cout = est_(NB-1).
- Exact result: {cout, sum} = a + b + cin, computed at WIDTH+1 bits.
- err is 1 when {spec_cout, spec_sum} != {exact_cout, exact_sum}.
- FSM states: IDLE, CHECK, FIX, OUT.
  - IDLE: in_ready_o=1. On in_valid_i, latch a, b, cin and approx, then go to CHECK.
  - CHECK: compute both results from the latched operands.
    - If err=0 or approx=1: register the speculative result and err, set corrected=0, go to OUT.
    - Otherwise go to FIX.
  - FIX: register the exact result, set err=1 and corrected=1, go to OUT.
  - OUT: out_valid_o=1.
    - On out_ready_i, the result retires.
    - If in_valid_i is also 1, in_ready_o=1 and the new operands are latched, and the next state is CHECK. Otherwise the next state is IDLE.
- in_ready_o = (state==IDLE) | (state==OUT & out_ready_i). It is combinational from out_ready_i.
- Counter:
  - Increments by 1 in CHECK when err=1, regardless of approx.
  - Saturates at all-ones.
  - clr_cnt_i has priority over a simultaneous increment; the result is 0.
- Outputs are stable while out_valid_o=1 and out_ready_i=0.

## Timing
- Reset values: state=IDLE, out_valid_o=0, in_ready_o=1, sum_o=0, cout_o=0, err_o=0, corrected_o=0, err_cnt_o=0.
- Latency from the accept edge to out_valid_o:
  - 2 cycles when there is no error or approx=1.
  - 3 cycles when a correction occurs.
- Throughput:
  - One result per 2 cycles with back-to-back accept in OUT.
  - One result per 3 cycles with corrections.
- An async reset mid-operation (CHECK, FIX or OUT) drops the pending result. No output pulse follows, and the counter is cleared.
- in_valid_i in CHECK or FIX is ignored (in_ready_o=0). The operands must be held by the source.

## Test plan
1. Reset, then WIDTH=8, a=0x0F, b=0x01, cin=0, approx=0 -> after 2 cycles: sum=0x10, cout=0, err=0, corrected=0, err_cnt=0.
2. a=0x0F, b=0x00, cin=1, approx=0 -> block-0 estimate is 0 (sel=1, pre=0), so a misprediction occurs. After 3 cycles: sum=0x10, cout=0, err=1, corrected=1, err_cnt=1.
3. Same operands with approx=1 -> after 2 cycles: sum=0x00, cout=0, err=1, corrected=0, err_cnt increments.
4. Hold out_ready_i=0 for 5 cycles in OUT -> outputs stay constant and in_ready_o=0. Then raise out_ready_i together with a new in_valid_i -> the new operand is accepted on the same edge and the result appears 2 cycles later.
5. Preload the counter to 0xFFFF via repeated errors (or use CNT_W=2 and 3 errors), then trigger another error -> the counter stays saturated. Assert clr_cnt_i in the same cycle as an error -> err_cnt=0.
6. Assert rst_ni low during FIX -> out_valid_o=0 immediately, and no result is delivered after release. A random sweep of 10k operands checks: corrected results always equal a+b+cin, and err matches the reference model.
